// File: rtl/burst_ram_arbiter_pkg.sv
// Shared types and helpers for the two-master BurstRAM arbiter.
// Holds the FSM state encoding, the command encoding and the round-robin grant function.
package burst_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WRITE,
        READ
    } state_e;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    // A lone requester always wins; on a tie the master that was not granted last time wins.
    function automatic logic next_grant(input logic req0, input logic req1, input logic last);
        logic grant;
        if (req0 && req1) begin
            grant = ~last;
        end else if (req1) begin
            grant = 1'b1;
        end else if (req0) begin
            grant = 1'b0;
        end else begin
            grant = last;
        end
        return grant;
    endfunction

endpackage

// File: rtl/burst_ram_arbiter.sv
// Round-robin arbiter sharing one BurstRAM command/data port between two burst masters.
// A granted master owns the RAM from its command cycle until its whole burst completes or times out.
module burst_ram_arbiter
    import burst_arb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 4,
    parameter int DATA_WIDTH  = 64,
    parameter int BURST_COUNT = 4,
    parameter int RD_TIMEOUT  = 64
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    m0_req,
    input  logic                    m0_cmd,
    input  logic [ADDR_WIDTH-1:0]   m0_addr,
    input  logic [DATA_WIDTH-1:0]   m0_wr_data,
    output logic                    m0_ack,
    output logic                    m0_wr_ready,
    output logic [DATA_WIDTH-1:0]   m0_rd_data,
    output logic                    m0_rd_data_valid,
    output logic                    m0_done,
    output logic                    m0_err,

    input  logic                    m1_req,
    input  logic                    m1_cmd,
    input  logic [ADDR_WIDTH-1:0]   m1_addr,
    input  logic [DATA_WIDTH-1:0]   m1_wr_data,
    output logic                    m1_ack,
    output logic                    m1_wr_ready,
    output logic [DATA_WIDTH-1:0]   m1_rd_data,
    output logic                    m1_rd_data_valid,
    output logic                    m1_done,
    output logic                    m1_err,

    output logic                    br_cmd,
    output logic                    br_cmd_en,
    output logic [ADDR_WIDTH-1:0]   br_addr,
    output logic [DATA_WIDTH-1:0]   br_wr_data,
    output logic [DATA_WIDTH/8-1:0] br_data_mask,
    input  logic [DATA_WIDTH-1:0]   br_rd_data,
    input  logic                    br_rd_data_valid,
    input  logic                    br_init_calib,
    input  logic                    br_busy
);

    localparam int BW = (BURST_COUNT > 1) ? $clog2(BURST_COUNT) : 1;
    localparam int TW = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_COUNT - 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(RD_TIMEOUT - 1);

    state_e                  r_state;
    logic                    r_owner;
    logic                    r_last_grant;
    logic                    r_cmd;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [BW-1:0]           r_beat_cnt;
    logic [TW-1:0]           r_timer;
    logic                    r_done;
    logic                    r_err;

    state_e                  w_state_nxt;
    logic [BW-1:0]           w_beat_nxt;
    logic [TW-1:0]           w_timer_nxt;
    logic                    w_done_nxt;
    logic                    w_err_nxt;
    logic                    w_arb_go;
    logic                    w_grant;

    logic                    w_owner_ack;
    logic                    w_owner_wr;
    logic                    w_owner_rdv;

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_grant     = next_grant(m0_req, m1_req, r_last_grant);
        w_arb_go    = 1'b0;
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat_cnt;
        w_timer_nxt = r_timer;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;

        case (r_state)
            IDLE: begin
                if (br_init_calib && !br_busy && (m0_req || m1_req)) begin
                    w_arb_go    = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (r_cmd == CMD_WRITE) begin
                    // The command cycle already carries write beat 0.
                    if (BURST_COUNT == 1) begin
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                        w_beat_nxt  = '0;
                    end else begin
                        w_state_nxt = WRITE;
                        w_beat_nxt  = BW'(1);
                    end
                end else begin
                    w_state_nxt = READ;
                    w_beat_nxt  = '0;
                    w_timer_nxt = '0;
                end
            end
            WRITE: begin
                if (r_beat_cnt == LAST_BEAT) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                    w_beat_nxt  = '0;
                end else begin
                    w_beat_nxt = r_beat_cnt + BW'(1);
                end
            end
            READ: begin
                if (br_rd_data_valid) begin
                    w_timer_nxt = '0;
                    if (r_beat_cnt == LAST_BEAT) begin
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                        w_beat_nxt  = '0;
                    end else begin
                        w_beat_nxt = r_beat_cnt + BW'(1);
                    end
                end else if (r_timer == LAST_TICK) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                    w_err_nxt   = 1'b1;
                    w_timer_nxt = '0;
                    w_beat_nxt  = '0;
                end else begin
                    w_timer_nxt = r_timer + TW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // NOTE: non-blocking assignments so every register samples the pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_cmd        <= CMD_READ;
            r_addr       <= '0;
            r_beat_cnt   <= '0;
            r_timer      <= '0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_beat_cnt <= w_beat_nxt;
            r_timer    <= w_timer_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            if (w_arb_go) begin
                r_owner      <= w_grant;
                r_last_grant <= w_grant;
                r_cmd        <= w_grant ? m1_cmd : m0_cmd;
                r_addr       <= w_grant ? m1_addr : m0_addr;
            end
        end
    end

    // Everything toward the RAM is decoded from registered state; req never reaches br_cmd_en.
    always_comb begin
        w_owner_ack = (r_state == ISSUE);
        w_owner_wr  = ((r_state == ISSUE) && (r_cmd == CMD_WRITE)) || (r_state == WRITE);
        w_owner_rdv = (r_state == READ) && br_rd_data_valid;
    end

    assign br_cmd_en    = w_owner_ack;
    assign br_cmd       = w_owner_ack ? r_cmd : CMD_READ;
    assign br_addr      = w_owner_ack ? r_addr : '0;
    assign br_wr_data   = w_owner_wr ? (r_owner ? m1_wr_data : m0_wr_data) : '0;
    assign br_data_mask = '0;

    assign m0_ack           = w_owner_ack && !r_owner;
    assign m0_wr_ready      = w_owner_wr  && !r_owner;
    assign m0_rd_data       = br_rd_data;
    assign m0_rd_data_valid = w_owner_rdv && !r_owner;
    assign m0_done          = r_done && !r_owner;
    assign m0_err           = r_err  && !r_owner;

    assign m1_ack           = w_owner_ack && r_owner;
    assign m1_wr_ready      = w_owner_wr  && r_owner;
    assign m1_rd_data       = br_rd_data;
    assign m1_rd_data_valid = w_owner_rdv && r_owner;
    assign m1_done          = r_done && r_owner;
    assign m1_err           = r_err  && r_owner;

endmodule

// File: tb/tb_burst_ram_arbiter.sv
// Directed bench for burst_ram_arbiter with a small behavioural BurstRAM (4 beats, 6-cycle read latency).
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_burst_ram_arbiter;

    localparam int AW = 4;
    localparam int DW = 64;

    logic          clk;
    logic          rst;
    logic          m0_req, m0_cmd, m1_req, m1_cmd;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wr_data, m1_wr_data;
    logic          m0_ack, m0_wr_ready, m0_rd_data_valid, m0_done, m0_err;
    logic          m1_ack, m1_wr_ready, m1_rd_data_valid, m1_done, m1_err;
    logic [DW-1:0] m0_rd_data, m1_rd_data;
    logic          br_cmd, br_cmd_en;
    logic [AW-1:0] br_addr;
    logic [DW-1:0] br_wr_data, br_rd_data;
    logic [7:0]    br_data_mask;
    logic          br_rd_data_valid, br_init_calib, br_busy;

    burst_ram_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_COUNT(4), .RD_TIMEOUT(64)
    ) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_cmd(m0_cmd), .m0_addr(m0_addr), .m0_wr_data(m0_wr_data),
        .m0_ack(m0_ack), .m0_wr_ready(m0_wr_ready), .m0_rd_data(m0_rd_data),
        .m0_rd_data_valid(m0_rd_data_valid), .m0_done(m0_done), .m0_err(m0_err),
        .m1_req(m1_req), .m1_cmd(m1_cmd), .m1_addr(m1_addr), .m1_wr_data(m1_wr_data),
        .m1_ack(m1_ack), .m1_wr_ready(m1_wr_ready), .m1_rd_data(m1_rd_data),
        .m1_rd_data_valid(m1_rd_data_valid), .m1_done(m1_done), .m1_err(m1_err),
        .br_cmd(br_cmd), .br_cmd_en(br_cmd_en), .br_addr(br_addr), .br_wr_data(br_wr_data),
        .br_data_mask(br_data_mask), .br_rd_data(br_rd_data), .br_rd_data_valid(br_rd_data_valid),
        .br_init_calib(br_init_calib), .br_busy(br_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- BurstRAM model ----------------
    logic [DW-1:0] mem [64];
    logic [5:0]    wr_ptr, rd_ptr;
    int            wr_left, rd_wait, rd_left;
    logic          model_valid;
    logic [DW-1:0] model_data;
    bit            mute;
    logic          stray;

    assign br_rd_data_valid = model_valid | stray;
    assign br_rd_data       = model_data;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 64'hC0DE_0000_0000_0000 | 64'(i);
    end

    always @(posedge clk) begin
        if (rst) begin
            model_valid <= 1'b0;
            model_data  <= '0;
            wr_left     <= 0;
            rd_wait     <= 0;
            rd_left     <= 0;
        end else begin
            model_valid <= 1'b0;
            if (br_cmd_en && br_cmd) begin
                mem[{br_addr, 2'b00}] <= br_wr_data;
                wr_ptr  <= {br_addr, 2'b01};
                wr_left <= 3;
            end else if (wr_left > 0) begin
                mem[wr_ptr] <= br_wr_data;
                wr_ptr  <= wr_ptr + 6'd1;
                wr_left <= wr_left - 1;
            end
            if (br_cmd_en && !br_cmd) begin
                rd_ptr  <= {br_addr, 2'b00};
                rd_wait <= 6;
                rd_left <= 4;
            end else if (rd_wait > 0) begin
                rd_wait <= rd_wait - 1;
            end else if (rd_left > 0) begin
                if (!mute) begin
                    model_valid <= 1'b1;
                    model_data  <= mem[rd_ptr];
                end
                rd_ptr  <= rd_ptr + 6'd1;
                rd_left <= rd_left - 1;
            end
        end
    end

    // ---------------- Monitors ----------------
    logic [DW-1:0] q0 [$];
    logic [DW-1:0] q1 [$];
    int n_cmd_en, n_dbl, n_mask, n_m1_act;
    bit in_burst;

    always @(negedge clk) begin
        if (rst) begin
            in_burst = 1'b0;
        end else begin
            if (br_cmd_en) begin
                if (in_burst) n_dbl++;
                in_burst = 1'b1;
                n_cmd_en++;
            end
            if (m0_done || m1_done) in_burst = 1'b0;
            if (br_data_mask !== 8'h00) n_mask++;
            if (m1_ack || m1_wr_ready || m1_rd_data_valid || m1_done) n_m1_act++;
            if (m0_rd_data_valid) q0.push_back(m0_rd_data);
            if (m1_rd_data_valid) q1.push_back(m1_rd_data);
        end
    end

    // ---------------- Checking ----------------
    int n_pass, n_checks, n_fail;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    logic [DW-1:0] wbeat [4];
    int b_ack, b_nwr, b_first_wr, b_last_rd, b_done, b_nrd;
    logic b_err;

    // Raises req for master m and follows the burst; all cycle stamps count from the call.
    task automatic run_burst(input bit m, input logic cmd, input logic [AW-1:0] addr);
        int cyc = 0;
        int idx = 0;
        b_ack = -1; b_nwr = 0; b_first_wr = -1; b_last_rd = -1; b_done = -1; b_nrd = 0; b_err = 1'b0;
        if (m) begin m1_req = 1'b1; m1_cmd = cmd; m1_addr = addr; end
        else   begin m0_req = 1'b1; m0_cmd = cmd; m0_addr = addr; end
        while (b_done < 0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if ((m ? m1_ack : m0_ack) && b_ack < 0) begin
                b_ack = cyc;
                if (m) m1_req = 1'b0; else m0_req = 1'b0;
            end
            if (m ? m1_wr_ready : m0_wr_ready) begin
                if (b_first_wr < 0) b_first_wr = cyc;
                if (idx < 4) begin
                    if (m) m1_wr_data = wbeat[idx]; else m0_wr_data = wbeat[idx];
                end
                idx++;
                b_nwr++;
            end
            if (m ? m1_rd_data_valid : m0_rd_data_valid) begin
                b_last_rd = cyc;
                b_nrd++;
            end
            if (m ? m1_done : m0_done) begin
                b_done = cyc;
                b_err  = m ? m1_err : m0_err;
            end
        end
        if (m) m1_req = 1'b0; else m0_req = 1'b0;
    endtask

    int   snap, n_acks, cyc, n;
    logic [2:0] order;
    bit   seen;

    initial begin
        rst = 1'b1; stray = 1'b0; mute = 1'b0;
        br_init_calib = 1'b0; br_busy = 1'b1;
        m0_req = 1'b0; m0_cmd = 1'b0; m0_addr = '0; m0_wr_data = '0;
        m1_req = 1'b0; m1_cmd = 1'b0; m1_addr = '0; m1_wr_data = '0;
        n_pass = 0; n_checks = 0; n_fail = 0;
        tick(3);

        // Reset state
        check("rst_ctrl_outs", 64'({m0_ack, m0_wr_ready, m0_rd_data_valid, m0_done, m0_err,
                                    m1_ack, m1_wr_ready, m1_rd_data_valid, m1_done, m1_err}), 64'h0);
        check("rst_br_outs", 64'({br_cmd, br_cmd_en, br_addr, br_data_mask}), 64'h0);
        rst = 1'b0;

        // 1) m0 read addr 2, held back by calib/busy
        m0_req = 1'b1; m0_cmd = 1'b0; m0_addr = 4'd2;
        snap = n_cmd_en;
        tick(4);
        check("no_cmd_while_uncalibrated", 64'(n_cmd_en - snap), 64'd0);
        br_init_calib = 1'b1;
        tick(3);
        check("no_cmd_while_busy", 64'(n_cmd_en - snap), 64'd0);
        check("no_ack_while_busy", 64'(m0_ack), 64'd0);
        br_busy = 1'b0;
        snap = n_m1_act;
        q0.delete();
        run_burst(1'b0, 1'b0, 4'd2);
        check("rd_m0_ack_latency", 64'(b_ack), 64'd1);
        check("rd_m0_beats", 64'(b_nrd), 64'd4);
        check("rd_m0_done_after_last", 64'(b_done), 64'(b_last_rd + 1));
        check("rd_m0_err", 64'(b_err), 64'd0);
        for (int i = 0; i < 4; i++)
            check($sformatf("rd_m0_word%0d", i), q0[i], 64'hC0DE_0000_0000_0008 + 64'(i));
        check("rd_m1_silent", 64'(n_m1_act - snap), 64'd0);

        // 2) m1 write addr 3, then read it back
        wbeat[0] = 64'h1111_1111_1111_1111; wbeat[1] = 64'h2222_2222_2222_2222;
        wbeat[2] = 64'h3333_3333_3333_3333; wbeat[3] = 64'h4444_4444_4444_4444;
        run_burst(1'b1, 1'b1, 4'd3);
        check("wr_m1_ack_latency", 64'(b_ack), 64'd1);
        check("wr_m1_ready_count", 64'(b_nwr), 64'd4);
        check("wr_m1_first_ready_at_ack", 64'(b_first_wr), 64'(b_ack));
        check("wr_m1_done_time", 64'(b_done), 64'(b_ack + 4));
        q1.delete();
        run_burst(1'b1, 1'b0, 4'd3);
        check("rb_m1_beats", 64'(b_nrd), 64'd4);
        check("rb_m1_word0", q1[0], 64'h1111_1111_1111_1111);
        check("rb_m1_word1", q1[1], 64'h2222_2222_2222_2222);
        check("rb_m1_word2", q1[2], 64'h3333_3333_3333_3333);
        check("rb_m1_word3", q1[3], 64'h4444_4444_4444_4444);

        // 3) Both request from reset: m0, m1, m0
        rst = 1'b1; tick(2); rst = 1'b0;
        q0.delete(); q1.delete();
        m0_req = 1'b1; m0_cmd = 1'b0; m0_addr = 4'd0;
        m1_req = 1'b1; m1_cmd = 1'b0; m1_addr = 4'd1;
        n_acks = 0; cyc = 0; order = 3'b111;
        while (n_acks < 3 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (m0_ack) begin order[n_acks] = 1'b0; n_acks++; end
            else if (m1_ack) begin order[n_acks] = 1'b1; n_acks++; end
        end
        m0_req = 1'b0; m1_req = 1'b0;
        check("rr_ack_count", 64'(n_acks), 64'd3);
        check("rr_order", 64'(order), 64'b010);
        seen = 1'b0; cyc = 0;
        while (!seen && cyc < 100) begin
            @(negedge clk);
            cyc++;
            seen = m0_done;
        end
        check("rr_last_done", 64'(seen), 64'd1);
        check("rr_m0_beats", 64'(q0.size()), 64'd8);
        check("rr_m1_beats", 64'(q1.size()), 64'd4);
        check("rr_m1_word0", q1[0], 64'hC0DE_0000_0000_0004);

        // 4) Read timeout, then normal service of m1
        mute = 1'b1;
        run_burst(1'b0, 1'b0, 4'd1);
        check("to_done_cycles_after_ack", 64'(b_done - b_ack), 64'd65);
        check("to_err", 64'(b_err), 64'd1);
        check("to_no_beats", 64'(b_nrd), 64'd0);
        mute = 1'b0;
        q1.delete();
        run_burst(1'b1, 1'b0, 4'd2);
        check("post_to_m1_ack", 64'(b_ack), 64'd1);
        check("post_to_m1_beats", 64'(b_nrd), 64'd4);
        check("post_to_m1_err", 64'(b_err), 64'd0);
        check("post_to_m1_word3", q1[3], 64'hC0DE_0000_0000_000B);

        // 5) Reset during write beat 2
        wbeat[0] = 64'hAAAA_0000_0000_0000; wbeat[1] = 64'hAAAA_0000_0000_0001;
        wbeat[2] = 64'hAAAA_0000_0000_0002; wbeat[3] = 64'hAAAA_0000_0000_0003;
        m0_req = 1'b1; m0_cmd = 1'b1; m0_addr = 4'd5;
        n = 0; cyc = 0;
        while (n < 3 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (m0_ack) m0_req = 1'b0;
            if (m0_wr_ready) begin m0_wr_data = wbeat[n]; n++; end
        end
        check("rst_reached_beat2", 64'(n), 64'd3);
        rst = 1'b1;
        tick(1);
        check("midrst_ctrl_outs", 64'({m0_ack, m0_wr_ready, m0_rd_data_valid, m0_done, m0_err,
                                       m1_ack, m1_wr_ready, m1_rd_data_valid, m1_done, m1_err}), 64'h0);
        check("midrst_br_outs", 64'({br_cmd, br_cmd_en, br_addr, br_data_mask}), 64'h0);
        check("midrst_wr_data", br_wr_data, 64'h0);
        rst = 1'b0;
        run_burst(1'b0, 1'b0, 4'd2);
        check("after_rst_ack_latency", 64'(b_ack), 64'd1);
        check("after_rst_beats", 64'(b_nrd), 64'd4);

        // 6) Stray valid while idle
        tick(2);
        q0.delete(); q1.delete();
        stray = 1'b1;
        tick(1);
        check("stray_m0_rdv", 64'(m0_rd_data_valid), 64'd0);
        check("stray_m1_rdv", 64'(m1_rd_data_valid), 64'd0);
        tick(2);
        stray = 1'b0;
        tick(1);
        check("stray_no_beats", 64'(q0.size() + q1.size()), 64'd0);
        run_burst(1'b1, 1'b0, 4'd1);
        check("stray_m1_beats", 64'(b_nrd), 64'd4);
        check("stray_m1_done_after_last", 64'(b_done), 64'(b_last_rd + 1));
        check("stray_m1_word0", q1[0], 64'hC0DE_0000_0000_0004);

        check("single_cmd_per_burst", 64'(n_dbl), 64'd0);
        check("mask_always_zero", 64'(n_mask), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/burst_ram_arbiter.md
Name: burst_ram_arbiter

Overview:
- Shares one BurstRAM command/data interface between two requesters, e.g. RAMIO cache (m0) and a boot/DMA loader (m1).
- Round-robin arbitration per whole burst. The granted requester owns the RAM until all beats of its read or write burst complete.
- Sits between the requesters' br_-style ports and the BurstRAM instance.

Parameters:
- ADDR_WIDTH, 4, width of burst RAM address (RAM_DEPTH_BITWIDTH)
- DATA_WIDTH, 64, burst beat width
- BURST_COUNT, 4, beats per read or write burst
- RD_TIMEOUT, 64, max cycles in READ without a valid beat before abort

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- mN_req  in  1  (N=0,1) request; held high, with cmd/addr stable, until mN_ack
- mN_cmd  in  1  0: read, 1: write
- mN_addr  in  ADDR_WIDTH  burst address
- mN_wr_data  in  DATA_WIDTH  current write beat
- mN_ack  out  1  command issued to RAM this cycle
- mN_wr_ready  out  1  mN_wr_data consumed this cycle; master advances to next beat
- mN_rd_data  out  DATA_WIDTH  read beat (br_rd_data broadcast)
- mN_rd_data_valid  out  1  read beat valid, owner only
- mN_done  out  1  one-cycle pulse: burst finished
- mN_err  out  1  qualifies mN_done: read timed out
- br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask  out  1/1/ADDR_WIDTH/DATA_WIDTH/DATA_WIDTH/8  to BurstRAM
- br_rd_data, br_rd_data_valid, br_init_calib, br_busy  in  DATA_WIDTH/1/1/1  from BurstRAM

Behaviour:
- Reset values:
  - state=IDLE, owner=0, last_grant=1 (m0 wins the first tie), counters=0.
  - All mN_* outputs 0; br_cmd_en=0, br_cmd=0, br_addr=0, br_data_mask=0 (always 0).
- States: IDLE, ISSUE, WRITE, READ.
- IDLE:
  - Stays while br_init_calib=0 or br_busy=1.
  - Otherwise, if any req: grant the sole requester, or on a tie the one != last_grant.
  - Register owner, cmd, addr; last_grant<=owner; go to ISSUE.
- ISSUE (exactly 1 cycle):
  - br_cmd_en=1; br_cmd/br_addr from the registered copy; mOwner_ack=1.
  - Write: this cycle is beat 0; br_wr_data=mOwner_wr_data, mOwner_wr_ready=1, beat_cnt<=1, go WRITE (or IDLE+done if BURST_COUNT=1).
  - Read: beat_cnt<=0, timer<=0, go READ.
- WRITE:
  - br_wr_data=mOwner_wr_data and mOwner_wr_ready=1 every cycle; beat_cnt++.
  - When beat_cnt=BURST_COUNT-1 is consumed: mOwner_done=1 the next cycle, go IDLE.
- READ:
  - Each br_rd_data_valid: mOwner_rd_data_valid=1 in the same cycle (combinational route); beat_cnt++; timer<=0.
  - On the BURST_COUNT-th beat: done pulse next cycle, go IDLE.
  - No beat for RD_TIMEOUT cycles: done+err pulse, go IDLE.
- Latency: req sampled in IDLE at edge t -> ack/br_cmd_en at cycle t+1. Min gap between bursts: done cycle = IDLE, so the next ISSUE is 1 cycle later.
- Non-owner: ack, wr_ready, rd_data_valid, done all 0; its req stays pending and is ignored until IDLE.
- br_rd_data_valid outside READ is dropped; no master sees it.
- req deasserted before ack: request is withdrawn if still in IDLE. After ISSUE it cannot be cancelled; the burst completes.
- Simultaneous done and a new req: the new req is arbitrated in the following IDLE cycle.
- rst mid-burst: immediate return to reset values. The BurstRAM's own reset is external; the integrator resets both together.
- br_cmd_en is decoded from the registered state only; no combinational path from req.

Decomposition:
- Package burst_arb_pkg:
  - State enum (IDLE, ISSUE, WRITE, READ).
  - Localparams CMD_READ=0, CMD_WRITE=1.
  - Function next_grant(req0, req1, last).
- No sub-module needed. The counter/timer and the grant function live inline.

Test Plan (BurstRAM model, BURST_COUNT=4, CYCLES_BEFORE_DATA_VALID=6):
- Hold m0_req=1 read addr 2 while br_busy=1, then release -> no br_cmd_en until br_busy=0 and br_init_calib=1; ack one cycle after release; m0 gets 4 valid beats equal to RAM words 8..11; m0_done 1 cycle after 4th beat; m1 sees nothing.
- m1 write addr 3, data 0x11..,0x22..,0x33..,0x44.. -> 4 wr_ready cycles starting at ack; a subsequent m1 read of addr 3 returns the same 4 values.
- m0 and m1 both req from reset -> m0 first, m1 second, then m0 again with both held (alternation). Never two br_cmd_en within one burst.
- m0 read with the model forced never to assert valid -> m0_done=1, m0_err=1 after 64 cycles; a subsequent m1 req is served normally.
- rst=1 during WRITE beat 2 -> next cycle all outputs 0, state IDLE; a fresh m0 read after reset is ack'd 1 cycle after req.
- Stray br_rd_data_valid injected in IDLE -> no mN_rd_data_valid; beat counters unchanged.
